// File: rtl/sprite_index_pipe.sv
// Three-stage sprite-sheet index generator: per-slot hit/ROM index for each viewport pixel,
// double-buffered slot attributes committed on frame_start, lowest-slot-wins selection.
module sprite_index_pipe #(
   parameter int unsigned NUM_SPR = 4,
   parameter int unsigned ADDR_W  = 18,
   parameter int          VIEW_X0 = 203,
   parameter int          VIEW_Y0 = 152,
   parameter int          VIEW_W  = 233,
   parameter int          VIEW_H  = 176,
   localparam int unsigned SEL_W  = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        frame_start,
   input  logic                        attr_we,
   input  logic [SEL_W-1:0]            attr_sel,
   input  logic [9:0]                  attr_pos_x,
   input  logic [9:0]                  attr_pos_y,
   input  logic [3:0]                  attr_frame_x,
   input  logic [3:0]                  attr_frame_y,
   input  logic [8:0]                  attr_img_w,
   input  logic [8:0]                  attr_img_h,
   input  logic [8:0]                  attr_sheet_w,
   input  logic [ADDR_W-1:0]           attr_base,
   input  logic                        attr_flip,
   input  logic                        attr_en,
   input  logic                        pix_valid,
   input  logic [9:0]                  DrawX,
   input  logic [9:0]                  DrawY,
   output logic                        out_valid,
   output logic [NUM_SPR-1:0]          out_hit,
   output logic [NUM_SPR*ADDR_W-1:0]   out_index,
   output logic                        win_hit,
   output logic [SEL_W-1:0]            win_id,
   output logic [ADDR_W-1:0]           win_index
);

   typedef struct packed {
      logic              en;
      logic              flip;
      logic [ADDR_W-1:0] base;
      logic [8:0]        sheet_w;
      logic [8:0]        img_h;
      logic [8:0]        img_w;
      logic [3:0]        frame_y;
      logic [3:0]        frame_x;
      logic [9:0]        pos_y;
      logic [9:0]        pos_x;
   } attr_t;

   typedef struct packed {
      logic              hit;
      logic [8:0]        col;
      logic [8:0]        row;
      logic              flip;
      logic [ADDR_W-1:0] base;
      logic [8:0]        sheet_w;
      logic [8:0]        img_h;
      logic [8:0]        img_w;
      logic [3:0]        frame_y;
      logic [3:0]        frame_x;
   } s1_t;

   typedef struct packed {
      logic              hit;
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] prod_a;
      logic [ADDR_W-1:0] prod_b;
   } s2_t;

   localparam logic signed [11:0] VX0 = 12'(VIEW_X0);
   localparam logic signed [11:0] VX1 = 12'(VIEW_X0 + VIEW_W);
   localparam logic signed [11:0] VY0 = 12'(VIEW_Y0);
   localparam logic signed [11:0] VY1 = 12'(VIEW_Y0 + VIEW_H);

   attr_t [NUM_SPR-1:0]        shadow_q, shadow_d, active_q, active_d;
   logic                       v1_q, v1_d, v2_q, v2_d;
   s1_t   [NUM_SPR-1:0]        s1_q, s1_d;
   s2_t   [NUM_SPR-1:0]        s2_q, s2_d;
   logic                       out_valid_q, out_valid_d;
   logic [NUM_SPR-1:0]         out_hit_q, out_hit_d;
   logic [NUM_SPR*ADDR_W-1:0]  out_index_q, out_index_d;
   logic                       win_hit_q, win_hit_d;
   logic [SEL_W-1:0]           win_id_q, win_id_d;
   logic [ADDR_W-1:0]          win_index_q, win_index_d;

   // The commit copies shadow_d, so a write landing with frame_start is committed too.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (attr_we && (32'(attr_sel) < NUM_SPR)) begin
         shadow_d[attr_sel] = '{en: attr_en, flip: attr_flip, base: attr_base,
                                sheet_w: attr_sheet_w, img_h: attr_img_h, img_w: attr_img_w,
                                frame_y: attr_frame_y, frame_x: attr_frame_x,
                                pos_y: attr_pos_y, pos_x: attr_pos_x};
      end
      if (frame_start) begin
         active_d = shadow_d;
      end
   end

   // S1: window test in signed 12-bit so sprites hanging off the top/left clip instead of wrapping.
   always_comb begin
      logic signed [11:0] dx, dy, x_lo, y_lo, col, row;
      logic               in_view;
      attr_t              a;
      s1_d    = '0;
      v1_d    = pix_valid;
      dx      = $signed({2'b00, DrawX});
      dy      = $signed({2'b00, DrawY});
      in_view = (dx >= VX0) && (dx < VX1) && (dy >= VY0) && (dy < VY1);
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
         a    = active_q[i];
         x_lo = VX0 + $signed({2'b00, a.pos_x}) - $signed({4'b0000, a.img_w[8:1]});
         y_lo = VY0 + $signed({2'b00, a.pos_y});
         col  = dx - x_lo;
         row  = dy - y_lo;
         s1_d[i].hit     = pix_valid && a.en && in_view &&
                           !col[11] && (col < $signed({3'b000, a.img_w})) &&
                           !row[11] && (row < $signed({3'b000, a.img_h}));
         s1_d[i].col     = col[8:0];
         s1_d[i].row     = row[8:0];
         s1_d[i].flip    = a.flip;
         s1_d[i].base    = a.base;
         s1_d[i].sheet_w = a.sheet_w;
         s1_d[i].img_h   = a.img_h;
         s1_d[i].img_w   = a.img_w;
         s1_d[i].frame_y = a.frame_y;
         s1_d[i].frame_x = a.frame_x;
      end
   end

   // S2: products are formed directly at ADDR_W; truncation commutes with the final modulo.
   always_comb begin
      logic [8:0] colf;
      s2_d = '0;
      v2_d = v1_q;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
         colf = s1_q[i].flip ? (s1_q[i].img_w - 9'd1 - s1_q[i].col) : s1_q[i].col;
         s2_d[i].hit    = s1_q[i].hit;
         s2_d[i].base   = s1_q[i].base;
         s2_d[i].prod_a = (ADDR_W'(s1_q[i].frame_y) * ADDR_W'(s1_q[i].img_h) +
                           ADDR_W'(s1_q[i].row)) * ADDR_W'(s1_q[i].sheet_w);
         s2_d[i].prod_b = ADDR_W'(s1_q[i].frame_x) * ADDR_W'(s1_q[i].img_w) + ADDR_W'(colf);
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] idx;
      out_valid_d = v2_q;
      out_hit_d   = '0;
      out_index_d = '0;
      win_hit_d   = 1'b0;
      win_id_d    = '0;
      win_index_d = '0;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
         idx = s2_q[i].hit ? (s2_q[i].base + s2_q[i].prod_a + s2_q[i].prod_b) : '0;
         out_hit_d[i]                   = s2_q[i].hit;
         out_index_d[i*ADDR_W +: ADDR_W] = idx;
         if (s2_q[i].hit && !win_hit_d) begin
            win_hit_d   = 1'b1;
            win_id_d    = SEL_W'(i);
            win_index_d = idx;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadow_q    <= '0;
         active_q    <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         s1_q        <= '0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
         out_hit_q   <= '0;
         out_index_q <= '0;
         win_hit_q   <= 1'b0;
         win_id_q    <= '0;
         win_index_q <= '0;
      end else begin
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         out_valid_q <= out_valid_d;
         out_hit_q   <= out_hit_d;
         out_index_q <= out_index_d;
         win_hit_q   <= win_hit_d;
         win_id_q    <= win_id_d;
         win_index_q <= win_index_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_hit   = out_hit_q;
   assign out_index = out_index_q;
   assign win_hit   = win_hit_q;
   assign win_id    = win_id_q;
   assign win_index = win_index_q;

endmodule

// File: tb/tb_sprite_index_pipe.sv
// Bench for sprite_index_pipe: directed test-plan cases plus random traffic scored against
// an integer model of the hit/index rules and a 3-cycle expected-output queue.
module tb_sprite_index_pipe;

   localparam int NS = 4;
   localparam int AW = 18;

   logic          Clk = 1'b0;
   logic          Reset, frame_start, attr_we, attr_flip, attr_en, pix_valid;
   logic [1:0]    attr_sel;
   logic [9:0]    attr_pos_x, attr_pos_y, DrawX, DrawY;
   logic [3:0]    attr_frame_x, attr_frame_y;
   logic [8:0]    attr_img_w, attr_img_h, attr_sheet_w;
   logic [AW-1:0] attr_base;
   logic          out_valid, win_hit;
   logic [NS-1:0] out_hit;
   logic [NS*AW-1:0] out_index;
   logic [1:0]    win_id;
   logic [AW-1:0] win_index;

   always #5 Clk = ~Clk;

   sprite_index_pipe #(.NUM_SPR(NS), .ADDR_W(AW)) dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .attr_we(attr_we),
      .attr_sel(attr_sel), .attr_pos_x(attr_pos_x), .attr_pos_y(attr_pos_y),
      .attr_frame_x(attr_frame_x), .attr_frame_y(attr_frame_y),
      .attr_img_w(attr_img_w), .attr_img_h(attr_img_h), .attr_sheet_w(attr_sheet_w),
      .attr_base(attr_base), .attr_flip(attr_flip), .attr_en(attr_en),
      .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .out_valid(out_valid), .out_hit(out_hit), .out_index(out_index),
      .win_hit(win_hit), .win_id(win_id), .win_index(win_index)
   );

   typedef struct { int px, py, fx, fy, w, h, sw, base, flip, en; } mattr_t;
   typedef struct packed {
      logic          valid;
      logic [NS-1:0] hit;
      logic [NS*AW-1:0] idx;
      logic          whit;
      logic [1:0]    wid;
      logic [AW-1:0] widx;
   } exp_t;

   mattr_t sh_m[NS], ac_m[NS];
   exp_t   expq[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model_eval();
      exp_t e;
      int   xlo, ylo, col, row, colf, x, y;
      longint idx;
      bit   inview;
      e = '0;
      e.valid = pix_valid;
      x = int'(DrawX);
      y = int'(DrawY);
      inview = (x >= 203) && (x < 203 + 233) && (y >= 152) && (y < 152 + 176);
      if (pix_valid) begin
         for (int i = 0; i < NS; i++) begin
            xlo = 203 + ac_m[i].px - ac_m[i].w / 2;
            ylo = 152 + ac_m[i].py;
            col = x - xlo;
            row = y - ylo;
            if (ac_m[i].en != 0 && inview && col >= 0 && col < ac_m[i].w &&
                row >= 0 && row < ac_m[i].h) begin
               colf = (ac_m[i].flip != 0) ? (ac_m[i].w - 1 - col) : col;
               idx = longint'(ac_m[i].base)
                     + longint'(ac_m[i].fy * ac_m[i].h + row) * ac_m[i].sw
                     + longint'(ac_m[i].fx * ac_m[i].w + colf);
               idx = idx % (64'd1 << AW);
               e.hit[i] = 1'b1;
               e.idx[i*AW +: AW] = idx[AW-1:0];
               if (!e.whit) begin
                  e.whit = 1'b1;
                  e.wid  = 2'(i);
                  e.widx = idx[AW-1:0];
               end
            end
         end
      end
      return e;
   endfunction

   task automatic model_update();
      if (Reset) begin
         for (int i = 0; i < NS; i++) begin
            sh_m[i] = '{default: 0};
            ac_m[i] = '{default: 0};
         end
      end else begin
         if (attr_we)
            sh_m[attr_sel] = '{px: int'(attr_pos_x), py: int'(attr_pos_y),
                               fx: int'(attr_frame_x), fy: int'(attr_frame_y),
                               w: int'(attr_img_w), h: int'(attr_img_h),
                               sw: int'(attr_sheet_w), base: int'(attr_base),
                               flip: int'(attr_flip), en: int'(attr_en)};
         if (frame_start) ac_m = sh_m;
      end
   endtask

   // One clock: score the current inputs, advance, then compare against the output now due.
   task automatic step();
      exp_t e;
      e = model_eval();
      if (Reset) begin
         expq.delete();
         repeat (3) expq.push_back('0);
      end else begin
         expq.push_back(e);
      end
      model_update();
      @(posedge Clk);
      #1;
      e = expq.pop_front();
      check("out_valid", out_valid, e.valid);
      check("out_hit",   out_hit,   e.hit);
      check("out_index", out_index, e.idx);
      check("win_hit",   win_hit,   e.whit);
      check("win_id",    win_id,    e.wid);
      check("win_index", win_index, e.widx);
   endtask

   task automatic wr(input int sel, input int px, input int py, input int fx, input int fy,
                     input int w, input int h, input int sw, input int base,
                     input int flip, input int en, input int commit);
      attr_we = 1'b1; attr_sel = 2'(sel);
      attr_pos_x = 10'(px); attr_pos_y = 10'(py);
      attr_frame_x = 4'(fx); attr_frame_y = 4'(fy);
      attr_img_w = 9'(w); attr_img_h = 9'(h); attr_sheet_w = 9'(sw);
      attr_base = AW'(base); attr_flip = flip[0]; attr_en = en[0];
      frame_start = commit[0];
      step();
      attr_we = 1'b0; frame_start = 1'b0;
   endtask

   task automatic probe(input int x, input int y);
      pix_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y);
      step();
      pix_valid = 1'b0;
      step();
      step();
   endtask

   initial begin
      Reset = 1'b1; frame_start = 1'b0; attr_we = 1'b0; attr_sel = '0;
      attr_pos_x = '0; attr_pos_y = '0; attr_frame_x = '0; attr_frame_y = '0;
      attr_img_w = 9'd1; attr_img_h = 9'd1; attr_sheet_w = '0; attr_base = '0;
      attr_flip = 1'b0; attr_en = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
      step();
      step();
      Reset = 1'b0;
      check("reset_valid", out_valid, 0);
      check("reset_index", out_index, 0);

      wr(0, 50, 20, 2, 1, 28, 26, 224, 0, 0, 1, 1);
      probe(239, 172);
      check("tp_hit0", out_hit[0], 1);
      check("tp_idx0", out_index[AW-1:0], 5880);
      check("tp_win0", win_id, 0);

      wr(0, 50, 20, 2, 1, 28, 26, 224, 0, 1, 1, 1);
      probe(239, 172);
      check("tp_flip_idx0", out_index[AW-1:0], 5907);
      probe(267, 172);
      check("tp_redge_hit0", out_hit[0], 0);
      check("tp_redge_idx0", out_index[AW-1:0], 0);

      wr(0, 50, 20, 2, 1, 28, 26, 224, 0, 0, 0, 0);
      wr(1, 100, 50, 1, 0, 20, 20, 100, 500, 0, 1, 0);
      wr(2, 105, 55, 0, 0, 20, 20, 100, 9000, 0, 1, 1);
      probe(300, 210);
      check("tp_ovl_whit", win_hit, 1);
      check("tp_ovl_wid", win_id, 1);
      check("tp_ovl_widx", win_index, 1327);
      wr(1, 100, 50, 1, 0, 20, 20, 100, 500, 0, 0, 1);
      probe(300, 210);
      check("tp_ovl_wid2", win_id, 2);

      wr(0, 50, 20, 2, 1, 28, 26, 224, 0, 0, 1, 1);
      wr(0, 100, 20, 2, 1, 28, 26, 224, 0, 0, 1, 0);
      probe(239, 172);
      check("tp_shadow_hold", out_index[AW-1:0], 5880);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      probe(289, 172);
      check("tp_commit_hit", out_hit[0], 1);
      check("tp_commit_idx", out_index[AW-1:0], 5880);
      wr(0, 50, 20, 2, 1, 28, 26, 224, 0, 0, 1, 1);
      probe(239, 172);
      check("tp_bypass_hit", out_hit[0], 1);

      wr(0, 5, 0, 0, 0, 28, 10, 224, 1000, 0, 1, 1);
      probe(202, 152);
      check("tp_clip_hit", out_hit[0], 0);
      probe(203, 152);
      check("tp_clip_idx", out_index[AW-1:0], 1009);

      for (int k = 0; k < 10; k++) begin
         pix_valid = 1'b1; DrawX = 10'(203 + k); DrawY = 10'd152;
         Reset = (k == 5);
         step();
         Reset = 1'b0;
         if (k == 5) begin
            check("rst_mid_valid", out_valid, 0);
            check("rst_mid_hit", out_hit, 0);
         end
      end
      check("rst_restart_valid", out_valid, 1);
      check("rst_slots_off", out_hit, 0);

      for (int n = 0; n < 4000; n++) begin
         attr_we = ($urandom_range(0, 3) == 0);
         if (attr_we) begin
            attr_sel = 2'($urandom_range(0, 3));
            attr_pos_x = 10'($urandom_range(0, 240));
            attr_pos_y = 10'($urandom_range(0, 180));
            attr_frame_x = 4'($urandom_range(0, 15));
            attr_frame_y = 4'($urandom_range(0, 15));
            attr_img_w = 9'(($urandom_range(0, 7) == 0) ? $urandom_range(1, 511) : $urandom_range(1, 90));
            attr_img_h = 9'($urandom_range(1, 90));
            attr_sheet_w = 9'($urandom_range(0, 511));
            attr_base = AW'($urandom);
            attr_flip = 1'($urandom_range(0, 1));
            attr_en = ($urandom_range(0, 3) != 0);
         end
         frame_start = ($urandom_range(0, 7) == 0);
         pix_valid = ($urandom_range(0, 9) != 0);
         DrawX = 10'($urandom_range(195, 445));
         DrawY = 10'($urandom_range(145, 335));
         Reset = ($urandom_range(0, 499) == 0);
         step();
      end
      Reset = 1'b0; attr_we = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_index_pipe.md
# sprite_index_pipe

Pipelined, multi-channel sprite-sheet address generator for the playfield viewport. For each incoming pixel coordinate it computes, for NUM_SPR independent sprite slots (Kirby, enemies, star projectiles), a hit flag and a flattened sprite-ROM index, and it selects the highest-priority hit. Slot attributes are double-buffered and committed at frame start, so the CPU/game FSM can update them mid-frame without tearing. It sits between the VGA controller's DrawX/DrawY and the sprite ROM readers/color mapper.

## Interface
- NUM_SPR, 4, number of sprite slots (1..8)
- ADDR_W, 18, width of sprite-ROM index
- VIEW_X0, 203, viewport left edge (screen px)
- VIEW_Y0, 152, viewport top edge (screen px)
- VIEW_W, 233, viewport width (px)
- VIEW_H, 176, viewport height (px)

- Clk  in  1  pixel clock; all state on rising edge
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse; commit shadow attributes to active set
- attr_we  in  1  write one slot's shadow attributes
- attr_sel  in  clog2(NUM_SPR)  slot being written
- attr_pos_x  in  10  sprite horizontal centre, viewport-relative
- attr_pos_y  in  10  sprite top row, viewport-relative
- attr_frame_x, attr_frame_y  in  4 each  animation frame column/row in sheet
- attr_img_w, attr_img_h  in  9 each  frame width/height (px, ≥1)
- attr_sheet_w  in  9  full sheet row pitch (px)
- attr_base  in  ADDR_W  sheet base address in shared ROM
- attr_flip  in  1  1 = horizontally mirrored
- attr_en  in  1  slot enabled
- pix_valid  in  1  DrawX/DrawY valid this cycle
- DrawX, DrawY  in  10 each  screen coordinate
- out_valid  out  1  outputs below correspond to a pixel
- out_hit  out  NUM_SPR  per-slot hit
- out_index  out  NUM_SPR*ADDR_W  per-slot index, slot i at [i*ADDR_W +: ADDR_W]
- win_hit  out  1  any slot hit
- win_id  out  clog2(NUM_SPR)  lowest-numbered hitting slot
- win_index  out  ADDR_W  index of win_id

## Operation
- Attribute store: shadow and active register sets per slot. attr_we writes shadow[attr_sel]. frame_start copies every shadow slot to active; if attr_we and frame_start coincide, the written value is included in the commit (bypass).
- Per slot, using active attributes (all arithmetic signed 12-bit):
  - x_lo = VIEW_X0 + pos_x − (img_w>>1); y_lo = VIEW_Y0 + pos_y.
  - col = DrawX − x_lo; row = DrawY − y_lo.
  - hit = en & in_view & 0 ≤ col < img_w & 0 ≤ row < img_h; in_view = VIEW_X0 ≤ DrawX < VIEW_X0+VIEW_W and VIEW_Y0 ≤ DrawY < VIEW_Y0+VIEW_H.
  - colf = flip ? (img_w−1−col) : col.
  - index = base + (frame_y*img_h + row)*sheet_w + frame_x*img_w + colf, truncated mod 2^ADDR_W.
  - Non-hit slot: index = 0.
- Winner: lowest slot number with hit; no hit → win_hit=0, win_id=0, win_index=0.
- Sprites partially left of/above viewport (x_lo or y_lo below origin) are clipped by in_view, never wrapped.

## Timing
- Three-stage pipeline, latency 3: pixel presented with pix_valid at cycle t → out_valid and results at t+3. Throughput one pixel/cycle, no stalls.
- S1: register pixel, snapshot active attributes, compute col/row/hit. S2: multiplies (frame_y*img_h+row)*sheet_w, frame_x*img_w, flip. S3: final sums, priority encode, register outputs.
- Attributes are captured in S1; a commit while pixels are in flight does not alter them.
- pix_valid=0 propagates as out_valid=0; other outputs then forced 0.
- Reset (sampled high at an edge): all shadow/active slots cleared (en=0), pipeline flushed; out_valid, out_hit, out_index, win_* all 0 from that edge. Reset mid-stream discards in-flight pixels; first valid output is 3 cycles after first pix_valid following Reset low.
- Reset has priority over attr_we and frame_start.

## Test plan
- Slot0: pos(50,20), img 28×26, sheet_w 224, frame(2,1), base 0, flip 0, en 1, commit; pixel (239,172) → 3 cycles later out_hit[0]=1, out_index[0]=5880, win_id=0.
- Same, flip=1 → out_index[0]=5907; pixel (267,172) → out_hit[0]=0, out_index[0]=0 (right edge exclusive).
- Slots 1 and 2 overlap at a pixel with slot 0 disabled → win_hit=1, win_id=1, win_index=out_index[1]; disable slot1 + commit → win_id=2.
- Write slot0 pos_x=100 without frame_start → outputs still use pos_x=50; pulse frame_start (also same-cycle write case) → new value used from next pixel.
- Sprite at pos(5,0), img_w 28 → pixel (202,152) no hit (clipped), (203,152) hit with col=9 → index base+9.
- Stream 10 valid pixels, assert Reset for 1 cycle mid-stream → out_valid=0 and all outputs 0 from that edge, slots disabled; restart → out_valid 3 cycles after first pix_valid.
